// File: rtl/id_ex_stage_pkg.sv
// Shared opcode definitions for the ID/EX pipeline register.
// Holds the opcode constants, the NOP opcode used for bubbles, the register
// index width, and the per-edge action type for the ID/EX register.
package id_ex_stage_pkg;

  localparam int unsigned REG_IND_W = 5;
  localparam int unsigned OPCODE_W  = 12;

  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 12'h000;
  localparam logic [OPCODE_W-1:0] OP_LW      = 12'h003;
  localparam logic [OPCODE_W-1:0] OP_ADDI    = 12'h013;
  localparam logic [OPCODE_W-1:0] OP_SW      = 12'h023;
  localparam logic [OPCODE_W-1:0] OP_ADD     = 12'h033;
  localparam logic [OPCODE_W-1:0] OP_JAL     = 12'h06F;

  // What the ID/EX register does on the next edge, after priority resolution.
  typedef enum logic [1:0] {
    ActLoad,
    ActHold,
    ActFlush,
    ActStall
  } reg_action_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Ports:
//   ex_valid, ex_memread, ex_rd_ind : instruction currently in EX
//   id_rs1_ind, id_rs2_ind          : source indices of the instruction in ID
//   id_is_oper2_immed, id_memwrite  : decide whether ID actually reads rs2
//   load_use                        : ID depends on a load still in EX
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_memread,
  input  logic [REG_IND_W-1:0] ex_rd_ind,
  input  logic [REG_IND_W-1:0] id_rs1_ind,
  input  logic [REG_IND_W-1:0] id_rs2_ind,
  input  logic                 id_is_oper2_immed,
  input  logic                 id_memwrite,
  output logic                 load_use
);

  logic uses_rs2;

  always_comb begin
    // Stores read rs2 as data even though operand 2 is the immediate.
    uses_rs2 = !id_is_oper2_immed || id_memwrite;
    load_use = ex_valid && ex_memread && (ex_rd_ind != '0) &&
               ((ex_rd_ind == id_rs1_ind) || (uses_rs2 && (ex_rd_ind == id_rs2_ind)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   ID_*                  : decoded instruction fields and control from ID
//   EX_flush              : squash the ID instruction (taken branch/jump)
//   hold                  : downstream freeze, register keeps its contents
//   EX_*, EX_valid        : registered fields and control seen by EX
//   PC_stall, IF_ID_stall : combinational load-use stall request
//   load_use_cnt          : saturating count of load-use bubbles inserted
// Edge priority: rst > EX_flush > hold > load_use > load.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODE_W-1:0]  ID_opcode,
  input  logic [REG_IND_W-1:0] ID_rs1_ind,
  input  logic [REG_IND_W-1:0] ID_rs2_ind,
  input  logic [REG_IND_W-1:0] ID_rd_ind,
  input  logic [DATA_W-1:0]    ID_rs1,
  input  logic [DATA_W-1:0]    ID_rs2,
  input  logic [DATA_W-1:0]    ID_immed,
  input  logic [DATA_W-1:0]    ID_PC,
  input  logic                 ID_regwrite,
  input  logic                 ID_memread,
  input  logic                 ID_memwrite,
  input  logic                 ID_is_oper2_immed,
  input  logic                 ID_is_jal,
  input  logic                 EX_flush,
  input  logic                 hold,
  output logic [OPCODE_W-1:0]  EX_opcode,
  output logic [REG_IND_W-1:0] EX_rs1_ind,
  output logic [REG_IND_W-1:0] EX_rs2_ind,
  output logic [REG_IND_W-1:0] EX_rd_ind,
  output logic [DATA_W-1:0]    EX_rs1,
  output logic [DATA_W-1:0]    EX_rs2,
  output logic [DATA_W-1:0]    EX_immed,
  output logic [DATA_W-1:0]    EX_PC,
  output logic                 EX_regwrite,
  output logic                 EX_memread,
  output logic                 EX_memwrite,
  output logic                 EX_is_oper2_immed,
  output logic                 EX_is_jal,
  output logic                 EX_valid,
  output logic                 PC_stall,
  output logic                 IF_ID_stall,
  output logic [CNT_W-1:0]     load_use_cnt
);

  logic        load_use;
  reg_action_e action;

  load_use_detect u_load_use_detect (
    .ex_valid          (EX_valid),
    .ex_memread        (EX_memread),
    .ex_rd_ind         (EX_rd_ind),
    .id_rs1_ind        (ID_rs1_ind),
    .id_rs2_ind        (ID_rs2_ind),
    .id_is_oper2_immed (ID_is_oper2_immed),
    .id_memwrite       (ID_memwrite),
    .load_use          (load_use)
  );

  always_comb begin
    // EX state may be stale while rst is high; never request a stall then.
    PC_stall    = load_use && !rst;
    IF_ID_stall = load_use && !rst;

    if (EX_flush)      action = ActFlush;
    else if (hold)     action = ActHold;
    else if (load_use) action = ActStall;
    else               action = ActLoad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      EX_opcode         <= NOP_OPCODE;
      EX_rs1_ind        <= '0;
      EX_rs2_ind        <= '0;
      EX_rd_ind         <= '0;
      EX_rs1            <= '0;
      EX_rs2            <= '0;
      EX_immed          <= '0;
      EX_PC             <= '0;
      EX_regwrite       <= 1'b0;
      EX_memread        <= 1'b0;
      EX_memwrite       <= 1'b0;
      EX_is_oper2_immed <= 1'b0;
      EX_is_jal         <= 1'b0;
      EX_valid          <= 1'b0;
      load_use_cnt      <= '0;
    end else begin
      unique case (action)
        ActFlush, ActStall: begin
          EX_opcode         <= NOP_OPCODE;
          EX_rs1_ind        <= '0;
          EX_rs2_ind        <= '0;
          EX_rd_ind         <= '0;
          EX_rs1            <= '0;
          EX_rs2            <= '0;
          EX_immed          <= '0;
          EX_PC             <= '0;
          EX_regwrite       <= 1'b0;
          EX_memread        <= 1'b0;
          EX_memwrite       <= 1'b0;
          EX_is_oper2_immed <= 1'b0;
          EX_is_jal         <= 1'b0;
          EX_valid          <= 1'b0;
        end
        ActHold: begin
        end
        ActLoad: begin
          EX_opcode         <= ID_opcode;
          EX_rs1_ind        <= ID_rs1_ind;
          EX_rs2_ind        <= ID_rs2_ind;
          EX_rd_ind         <= ID_rd_ind;
          EX_rs1            <= ID_rs1;
          EX_rs2            <= ID_rs2;
          EX_immed          <= ID_immed;
          EX_PC             <= ID_PC;
          EX_regwrite       <= ID_regwrite;
          EX_memread        <= ID_memread;
          EX_memwrite       <= ID_memwrite;
          EX_is_oper2_immed <= ID_is_oper2_immed;
          EX_is_jal         <= ID_is_jal;
          EX_valid          <= 1'b1;
        end
      endcase

      // Only load-use bubbles are counted; flush bubbles are not.
      if (action == ActStall && load_use_cnt != '1) begin
        load_use_cnt <= load_use_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ID_opcode;
  logic [4:0]  ID_rs1_ind, ID_rs2_ind, ID_rd_ind;
  logic [31:0] ID_rs1, ID_rs2, ID_immed, ID_PC;
  logic        ID_regwrite, ID_memread, ID_memwrite, ID_is_oper2_immed, ID_is_jal;
  logic        EX_flush, hold;

  logic [11:0] EX_opcode, s_opcode;
  logic [4:0]  EX_rs1_ind, EX_rs2_ind, EX_rd_ind, s_rs1_ind, s_rs2_ind, s_rd_ind;
  logic [31:0] EX_rs1, EX_rs2, EX_immed, EX_PC, s_rs1, s_rs2, s_immed, s_pc;
  logic        EX_regwrite, EX_memread, EX_memwrite, EX_is_oper2_immed, EX_is_jal, EX_valid;
  logic        s_regwrite, s_memread, s_memwrite, s_oper2, s_jal, s_valid;
  logic        PC_stall, IF_ID_stall, s_pc_stall, s_ifid_stall;
  logic [15:0] load_use_cnt;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ID_opcode(ID_opcode), .ID_rs1_ind(ID_rs1_ind),
    .ID_rs2_ind(ID_rs2_ind), .ID_rd_ind(ID_rd_ind), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_immed(ID_immed), .ID_PC(ID_PC), .ID_regwrite(ID_regwrite), .ID_memread(ID_memread),
    .ID_memwrite(ID_memwrite), .ID_is_oper2_immed(ID_is_oper2_immed), .ID_is_jal(ID_is_jal),
    .EX_flush(EX_flush), .hold(hold), .EX_opcode(EX_opcode), .EX_rs1_ind(EX_rs1_ind),
    .EX_rs2_ind(EX_rs2_ind), .EX_rd_ind(EX_rd_ind), .EX_rs1(EX_rs1), .EX_rs2(EX_rs2),
    .EX_immed(EX_immed), .EX_PC(EX_PC), .EX_regwrite(EX_regwrite), .EX_memread(EX_memread),
    .EX_memwrite(EX_memwrite), .EX_is_oper2_immed(EX_is_oper2_immed), .EX_is_jal(EX_is_jal),
    .EX_valid(EX_valid), .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall),
    .load_use_cnt(load_use_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .ID_opcode(ID_opcode), .ID_rs1_ind(ID_rs1_ind),
    .ID_rs2_ind(ID_rs2_ind), .ID_rd_ind(ID_rd_ind), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_immed(ID_immed), .ID_PC(ID_PC), .ID_regwrite(ID_regwrite), .ID_memread(ID_memread),
    .ID_memwrite(ID_memwrite), .ID_is_oper2_immed(ID_is_oper2_immed), .ID_is_jal(ID_is_jal),
    .EX_flush(EX_flush), .hold(hold), .EX_opcode(s_opcode), .EX_rs1_ind(s_rs1_ind),
    .EX_rs2_ind(s_rs2_ind), .EX_rd_ind(s_rd_ind), .EX_rs1(s_rs1), .EX_rs2(s_rs2),
    .EX_immed(s_immed), .EX_PC(s_pc), .EX_regwrite(s_regwrite), .EX_memread(s_memread),
    .EX_memwrite(s_memwrite), .EX_is_oper2_immed(s_oper2), .EX_is_jal(s_jal),
    .EX_valid(s_valid), .PC_stall(s_pc_stall), .IF_ID_stall(s_ifid_stall),
    .load_use_cnt(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic rw,
                       input logic mr, input logic mw, input logic oi, input logic jl);
    ID_opcode = op; ID_rs1_ind = r1; ID_rs2_ind = r2; ID_rd_ind = rd;
    ID_rs1 = v1; ID_rs2 = v2; ID_immed = imm; ID_PC = pc;
    ID_regwrite = rw; ID_memread = mr; ID_memwrite = mw; ID_is_oper2_immed = oi;
    ID_is_jal = jl;
  endtask

  // lw xRD, 8(x1)
  task automatic drive_lw(input logic [4:0] rd);
    drive(OP_LW, 5'd1, 5'd0, rd, 32'h100, 32'h0, 32'h8, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // add x6, x5, x7
  task automatic drive_add();
    drive(OP_ADD, 5'd5, 5'd7, 5'd6, 32'h11, 32'h22, 32'h0, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; EX_flush = 1'b0; hold = 1'b0;
    drive(NOP_OPCODE, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    n_cmp++; if (EX_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", EX_valid); end
    n_cmp++; if (EX_opcode !== 12'h000) begin n_err++; $display("FAIL reset_opcode: got %h want 000", EX_opcode); end
    n_cmp++; if (load_use_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", load_use_cnt); end
    n_cmp++; if (PC_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", PC_stall); end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    // jal-flavoured lw to also check that is_jal propagates on a load
    drive(OP_LW, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    n_cmp++; if (EX_valid !== 1'b1) begin n_err++; $display("FAIL lw_valid: got %b want 1", EX_valid); end
    n_cmp++; if (EX_rd_ind !== 5'd5) begin n_err++; $display("FAIL lw_rd: got %0d want 5", EX_rd_ind); end
    n_cmp++; if (EX_immed !== 32'h8 || EX_PC !== 32'h40 || EX_rs1 !== 32'h100) begin n_err++; $display("FAIL lw_data: got imm %h pc %h rs1 %h want 8 40 100", EX_immed, EX_PC, EX_rs1); end
    n_cmp++; if (EX_memread !== 1'b1 || EX_is_jal !== 1'b1 || EX_opcode !== OP_LW) begin n_err++; $display("FAIL lw_ctrl: got mr %b jal %b op %h want 1 1 %h", EX_memread, EX_is_jal, EX_opcode, OP_LW); end
    drive_add();
    #1;
    n_cmp++; if (PC_stall !== 1'b1 || IF_ID_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b%b want 11", PC_stall, IF_ID_stall); end
    tick();
    n_cmp++; if (EX_valid !== 1'b0 || EX_opcode !== 12'h0 || EX_rd_ind !== 5'd0 || EX_PC !== 32'h0) begin n_err++; $display("FAIL lu_bubble: got v %b op %h rd %0d pc %h want 0 0 0 0", EX_valid, EX_opcode, EX_rd_ind, EX_PC); end
    n_cmp++; if (load_use_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", load_use_cnt); end
    n_cmp++; if (PC_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_one_cycle: got %b want 0", PC_stall); end
    tick();
    n_cmp++; if (EX_opcode !== OP_ADD || EX_rd_ind !== 5'd6 || EX_valid !== 1'b1 || EX_rs2 !== 32'h22) begin n_err++; $display("FAIL lu_add_load: got op %h rd %0d v %b rs2 %h want %h 6 1 22", EX_opcode, EX_rd_ind, EX_valid, EX_rs2, OP_ADD); end
  endtask

  task automatic test_immed_no_stall();
    drive_lw(5'd5); tick();
    drive(OP_ADDI, 5'd7, 5'd5, 5'd6, 32'h3, 32'h0, 32'h4, 32'h48, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    n_cmp++; if (PC_stall !== 1'b0) begin n_err++; $display("FAIL addi_stall: got %b want 0", PC_stall); end
    tick();
    n_cmp++; if (EX_opcode !== OP_ADDI || EX_immed !== 32'h4 || EX_is_oper2_immed !== 1'b1) begin n_err++; $display("FAIL addi_load: got op %h imm %h oi %b want %h 4 1", EX_opcode, EX_immed, EX_is_oper2_immed, OP_ADDI); end
    n_cmp++; if (load_use_cnt !== 16'd1) begin n_err++; $display("FAIL addi_cnt: got %0d want 1", load_use_cnt); end
  endtask

  task automatic test_x0();
    drive_lw(5'd0); tick();
    drive(OP_ADD, 5'd0, 5'd3, 5'd6, 32'h0, 32'h5, 32'h0, 32'h4c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (PC_stall !== 1'b0 || IF_ID_stall !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %b%b want 00", PC_stall, IF_ID_stall); end
    tick();
    n_cmp++; if (EX_valid !== 1'b1 || EX_PC !== 32'h4c) begin n_err++; $display("FAIL x0_load: got v %b pc %h want 1 4c", EX_valid, EX_PC); end
  endtask

  task automatic test_store();
    drive_lw(5'd9); tick();
    drive(OP_SW, 5'd2, 5'd9, 5'd0, 32'h200, 32'h77, 32'hc, 32'h50, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    n_cmp++; if (PC_stall !== 1'b1) begin n_err++; $display("FAIL sw_stall: got %b want 1", PC_stall); end
    tick();
    n_cmp++; if (EX_valid !== 1'b0 || load_use_cnt !== 16'd2) begin n_err++; $display("FAIL sw_bubble: got v %b cnt %0d want 0 2", EX_valid, load_use_cnt); end
    n_cmp++; if (PC_stall !== 1'b0) begin n_err++; $display("FAIL sw_stall_end: got %b want 0", PC_stall); end
    tick();
    n_cmp++; if (EX_opcode !== OP_SW || EX_memwrite !== 1'b1 || EX_rs2 !== 32'h77) begin n_err++; $display("FAIL sw_load: got op %h mw %b rs2 %h want %h 1 77", EX_opcode, EX_memwrite, EX_rs2, OP_SW); end
  endtask

  task automatic test_hold();
    drive_lw(5'd5); tick();
    drive_add(); hold = 1'b1;
    #1;
    n_cmp++; if (PC_stall !== 1'b1) begin n_err++; $display("FAIL hold_stall: got %b want 1", PC_stall); end
    tick();
    n_cmp++; if (EX_rd_ind !== 5'd5 || EX_valid !== 1'b1 || EX_memread !== 1'b1 || EX_opcode !== OP_LW) begin n_err++; $display("FAIL hold_keep: got rd %0d v %b mr %b op %h want 5 1 1 %h", EX_rd_ind, EX_valid, EX_memread, EX_opcode, OP_LW); end
    n_cmp++; if (load_use_cnt !== 16'd2) begin n_err++; $display("FAIL hold_cnt: got %0d want 2", load_use_cnt); end
    n_cmp++; if (IF_ID_stall !== 1'b1) begin n_err++; $display("FAIL hold_stall_kept: got %b want 1", IF_ID_stall); end
    hold = 1'b0;
    tick();
    n_cmp++; if (EX_valid !== 1'b0 || load_use_cnt !== 16'd3) begin n_err++; $display("FAIL hold_release: got v %b cnt %0d want 0 3", EX_valid, load_use_cnt); end
    tick();
    n_cmp++; if (EX_rd_ind !== 5'd6) begin n_err++; $display("FAIL hold_add: got rd %0d want 6", EX_rd_ind); end
  endtask

  task automatic test_flush_hold();
    drive_lw(5'd5); tick();
    drive_add(); EX_flush = 1'b1; hold = 1'b1;
    tick();
    n_cmp++; if (EX_regwrite !== 1'b0 || EX_valid !== 1'b0 || EX_memread !== 1'b0) begin n_err++; $display("FAIL flush_bubble: got rw %b v %b mr %b want 0 0 0", EX_regwrite, EX_valid, EX_memread); end
    n_cmp++; if (load_use_cnt !== 16'd3) begin n_err++; $display("FAIL flush_cnt: got %0d want 3", load_use_cnt); end
    EX_flush = 1'b0; hold = 1'b0;
    tick();
    n_cmp++; if (EX_regwrite !== 1'b1 || EX_valid !== 1'b1) begin n_err++; $display("FAIL flush_after: got rw %b v %b want 1 1", EX_regwrite, EX_valid); end
  endtask

  task automatic test_reset_mid_stall();
    drive_lw(5'd5); tick();
    drive_add(); hold = 1'b1;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (PC_stall !== 1'b0 || IF_ID_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_gate: got %b%b want 00", PC_stall, IF_ID_stall); end
    tick();
    n_cmp++; if (EX_valid !== 1'b0 || EX_rd_ind !== 5'd0 || EX_regwrite !== 1'b0 || EX_PC !== 32'h0 || EX_rs1 !== 32'h0) begin n_err++; $display("FAIL rst_mid: got v %b rd %0d rw %b pc %h rs1 %h want all 0", EX_valid, EX_rd_ind, EX_regwrite, EX_PC, EX_rs1); end
    n_cmp++; if (load_use_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", load_use_cnt); end
    rst = 1'b0; hold = 1'b0;
    tick();
    n_cmp++; if (EX_valid !== 1'b1 || EX_rd_ind !== 5'd6) begin n_err++; $display("FAIL rst_first_load: got v %b rd %0d want 1 6", EX_valid, EX_rd_ind); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      drive_lw(5'd5); tick();
      drive_add(); tick();
      if (i == 2) begin
        n_cmp++; if (s_cnt !== 2'd3) begin n_err++; $display("FAIL sat_reach: got %0d want 3", s_cnt); end
      end
    end
    n_cmp++; if (s_cnt !== 2'd3) begin n_err++; $display("FAIL sat_hold: got %0d want 3", s_cnt); end
    n_cmp++; if (load_use_cnt !== 16'd4) begin n_err++; $display("FAIL sat_wide: got %0d want 4", load_use_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_immed_no_stall();
    test_x0();
    test_store();
    test_hold();
    test_flush_hold();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
